// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of programmable square-wave dividers with tick enables.
// Optional global phase realign on `sync` when CLKDIV_SYNC_EN is defined.
module clk_div_bank #(
   parameter int          CHANNELS    = 4,
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic [CHANNELS-1:0] div_wr,
   input  logic [CNT_W-1:0]    div_data,
   input  logic                sync,
   output logic [CHANNELS-1:0] slow_clk,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pend
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic sync_hit;

`ifdef CLKDIV_SYNC_EN
   assign sync_hit = sync;
`else
   logic sync_unused;
   assign sync_unused = sync;
   assign sync_hit    = 1'b0;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] div_q, div_d;
      logic [CNT_W-1:0] shadow_q, shadow_d;
      logic             pend_q, pend_d;
      logic             slow_q, slow_d;
      logic             tick_q, tick_d;
      logic [CNT_W-1:0] nxt_div;
      logic             clr;
      logic             wrap;

      // A write landing on a clear or wrap edge becomes active right away
      assign nxt_div = div_wr[i] ? div_data : shadow_q;
      assign clr     = sync_hit | ~en[i];
      assign wrap    = (cnt_q == div_q);

      always_comb begin
         cnt_d    = cnt_q;
         div_d    = div_q;
         shadow_d = shadow_q;
         pend_d   = pend_q;
         slow_d   = slow_q;
         tick_d   = 1'b0;
         if (clr) begin
            cnt_d    = '0;
            slow_d   = 1'b0;
            div_d    = nxt_div;
            shadow_d = nxt_div;
            pend_d   = 1'b0;
         end else if (wrap) begin
            cnt_d    = '0;
            slow_d   = ~slow_q;
            tick_d   = ~slow_q;
            div_d    = nxt_div;
            shadow_d = nxt_div;
            pend_d   = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (div_wr[i]) begin
               shadow_d = div_data;
               pend_d   = 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q    <= '0;
            div_q    <= DIV_RST;
            shadow_q <= DIV_RST;
            pend_q   <= 1'b0;
            slow_q   <= 1'b0;
            tick_q   <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            slow_q   <= slow_d;
            tick_q   <= tick_d;
         end
      end

      assign slow_clk[i] = slow_q;
      assign tick[i]     = tick_q;
      assign pend[i]     = pend_q;
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (4 channels, default divisor 100).
// Sync expectations follow CLKDIV_SYNC_EN when it is defined.
module tb_clk_div_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en;
   logic [3:0]  div_wr;
   logic [31:0] div_data;
   logic        sync;
   logic [3:0]  slow_clk;
   logic [3:0]  tick;
   logic [3:0]  pend;

   int errs   = 0;
   int checks = 0;

   clk_div_bank #(
      .CHANNELS   (4),
      .CNT_W      (32),
      .DEFAULT_DIV(100)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .div_wr  (div_wr),
      .div_data(div_data),
      .sync    (sync),
      .slow_clk(slow_clk),
      .tick    (tick),
      .pend    (pend)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      en       = 4'b0000;
      div_wr   = 4'b0000;
      div_data = 32'd0;
      sync     = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({slow_clk, tick, pend} !== 12'h000) begin
         errs++;
         $display("FAIL reset_outs got=%h want=000", {slow_clk, tick, pend});
      end
   endtask

   task automatic test_default_period();
      do_reset();
      en = 4'b1111;
      for (int e = 1; e <= 303; e++) begin
         step();
         if (e == 100) begin
            checks++;
            if (slow_clk !== 4'b0000) begin
               errs++;
               $display("FAIL dflt_e100 slow=%b want=0000", slow_clk);
            end
         end
         if (e == 101 || e == 303) begin
            checks++;
            if ({slow_clk, tick} !== 8'hff) begin
               errs++;
               $display("FAIL dflt_rise e=%0d slow=%b tick=%b want=1111/1111",
                        e, slow_clk, tick);
            end
         end
         if (e == 102) begin
            checks++;
            if ({slow_clk, tick} !== 8'hf0) begin
               errs++;
               $display("FAIL dflt_e102 slow=%b tick=%b want=1111/0000",
                        slow_clk, tick);
            end
         end
         if (e == 202) begin
            checks++;
            if ({slow_clk, tick} !== 8'h00) begin
               errs++;
               $display("FAIL dflt_fall slow=%b tick=%b want=0000/0000",
                        slow_clk, tick);
            end
         end
      end
   endtask

   task automatic test_div_write();
      do_reset();
      en = 4'b1111;
      for (int e = 1; e <= 50; e++) step();
      div_wr   = 4'b0001;
      div_data = 32'd3;
      step();
      div_wr = 4'b0000;
      checks++;
      if (pend !== 4'b0001) begin
         errs++;
         $display("FAIL wr_pend_set pend=%b want=0001", pend);
      end
      for (int e = 52; e <= 109; e++) begin
         step();
         if (e == 100) begin
            checks++;
            if ({slow_clk, pend} !== 8'h01) begin
               errs++;
               $display("FAIL wr_e100 slow=%b pend=%b want=0000/0001",
                        slow_clk, pend);
            end
         end
         if (e == 101) begin
            checks++;
            if ({slow_clk, tick, pend} !== 12'hff0) begin
               errs++;
               $display("FAIL wr_wrap slow=%b tick=%b pend=%b want=1111/1111/0000",
                        slow_clk, tick, pend);
            end
         end
         if (e == 104 || e == 105) begin
            checks++;
            if (slow_clk !== ((e == 104) ? 4'b1111 : 4'b1110)) begin
               errs++;
               $display("FAIL wr_half e=%0d slow=%b", e, slow_clk);
            end
         end
         if (e == 109) begin
            checks++;
            if ({slow_clk, tick} !== 8'hf1) begin
               errs++;
               $display("FAIL wr_rise2 slow=%b tick=%b want=1111/0001",
                        slow_clk, tick);
            end
         end
      end
   endtask

   task automatic test_wr_at_wrap();
      do_reset();
      en = 4'b0001;
      for (int e = 1; e <= 100; e++) step();
      div_wr   = 4'b0001;
      div_data = 32'd5;
      step();
      div_wr = 4'b0000;
      checks++;
      if ({slow_clk[0], tick[0], pend[0]} !== 3'b110) begin
         errs++;
         $display("FAIL wrapwr_e101 s/t/p=%b want=110",
                  {slow_clk[0], tick[0], pend[0]});
      end
      for (int e = 102; e <= 107; e++) begin
         step();
         if (e == 106 || e == 107) begin
            checks++;
            if (slow_clk[0] !== (e == 106)) begin
               errs++;
               $display("FAIL wrapwr_half e=%0d slow0=%b", e, slow_clk[0]);
            end
         end
      end
   endtask

   task automatic test_div_zero();
      do_reset();
      div_wr   = 4'b0010;
      div_data = 32'd0;
      step();
      div_wr = 4'b0000;
      en     = 4'b0010;
      for (int e = 1; e <= 4; e++) begin
         step();
         checks++;
         if ({slow_clk[1], tick[1]} !== {2{e[0]}}) begin
            errs++;
            $display("FAIL div0 e=%0d slow1=%b tick1=%b want=%b",
                     e, slow_clk[1], tick[1], e[0]);
         end
      end
   endtask

   task automatic test_disable();
      do_reset();
      en = 4'b1111;
      for (int e = 1; e <= 101; e++) step();
      en = 4'b1011;
      step();
      checks++;
      if ({slow_clk, tick} !== 8'hb0) begin
         errs++;
         $display("FAIL dis_drop slow=%b tick=%b want=1011/0000", slow_clk, tick);
      end
      en = 4'b1111;
      for (int e = 1; e <= 101; e++) begin
         step();
         if (e == 100 || e == 101) begin
            checks++;
            if ({slow_clk[2], tick[2]} !== {2{e == 101}}) begin
               errs++;
               $display("FAIL dis_reen e=%0d slow2=%b tick2=%b",
                        e, slow_clk[2], tick[2]);
            end
         end
      end
   endtask

   task automatic test_sync();
      logic [3:0] ws4, wt4, ws9, wt9, ws10, wt10;
`ifdef CLKDIV_SYNC_EN
      ws4 = 4'b0000; wt4 = 4'b0000;
      ws9 = 4'b0000; wt9 = 4'b0000;
      ws10 = 4'b1001; wt10 = 4'b1001;
`else
      ws4 = 4'b0001; wt4 = 4'b0001;
      ws9 = 4'b1001; wt9 = 4'b0000;
      ws10 = 4'b1001; wt10 = 4'b0000;
`endif
      do_reset();
      div_wr   = 4'b1001;
      div_data = 32'd9;
      step();
      div_wr = 4'b0000;
      en     = 4'b0001;
      for (int e = 1; e <= 3; e++) step();
      en = 4'b1001;
      for (int e = 1; e <= 2; e++) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 4 || k == 9 || k == 10) begin
            checks++;
            if ({slow_clk & 4'b1001, tick & 4'b1001} !==
                ((k == 4) ? {ws4, wt4} : (k == 9) ? {ws9, wt9} : {ws10, wt10})) begin
               errs++;
               $display("FAIL sync k=%0d slow=%b tick=%b", k, slow_clk, tick);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      en = 4'b1111;
      for (int e = 1; e <= 60; e++) step();
      div_wr   = 4'b0001;
      div_data = 32'd3;
      step();
      div_wr = 4'b0000;
      for (int e = 1; e <= 50; e++) step();
      rst = 1'b1;
      step();
      checks++;
      if ({slow_clk, tick, pend} !== 12'h000) begin
         errs++;
         $display("FAIL rstmid got=%h want=000", {slow_clk, tick, pend});
      end
      rst = 1'b0;
      for (int e = 1; e <= 303; e++) begin
         step();
         if (e == 4 || e == 202) begin
            checks++;
            if (slow_clk !== 4'b0000) begin
               errs++;
               $display("FAIL rstmid_low e=%0d slow=%b want=0000", e, slow_clk);
            end
         end
         if (e == 101 || e == 303) begin
            checks++;
            if ({slow_clk, tick} !== 8'hff) begin
               errs++;
               $display("FAIL rstmid_rise e=%0d slow=%b tick=%b", e, slow_clk, tick);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_period();
      test_div_write();
      test_wr_at_wrap();
      test_div_zero();
      test_disable();
      test_sync();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
